// File: rtl/rom_arbiter.sv
// rom_arbiter: two-requester, round-robin front end for a single-port ROM.
// One transaction in flight at a time: IDLE -> ISSUE -> WAIT -> RESP.
// Optional build macro ROM_ARB_RANGE_CHECK_EN: addresses >= DEPTH are answered
// straight from IDLE with an error response and never reach the ROM.
module rom_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]        state;
    logic              last_gnt;   // requester granted most recently
    logic              gnt_id;     // owner of the transaction in flight
    logic              any_req;
    logic              gsel;       // requester that would be granted now
    logic              accept;
    logic              rsp_hs;
    logic [ADDR_W-1:0] gnt_addr;

    // Round-robin pick: on a tie the requester not served last wins
    always_comb begin
        any_req  = req0_valid | req1_valid;
        gsel     = (req0_valid && req1_valid) ? ~last_gnt : req1_valid;
        gnt_addr = gsel ? req1_addr : req0_addr;
    end

    assign accept     = (state == S_IDLE) && any_req;
    // Ready is gated by rst_n so it drops the instant reset is applied
    assign req0_ready = rst_n && accept && !gsel;
    assign req1_ready = rst_n && accept && gsel;
    assign rsp0_valid = (state == S_RESP) && !gnt_id;
    assign rsp1_valid = (state == S_RESP) && gnt_id;
    assign rsp_hs     = (state == S_RESP) && (gnt_id ? rsp1_ready : rsp0_ready);
    assign rom_en     = (state == S_ISSUE);

`ifdef ROM_ARB_RANGE_CHECK_EN
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    logic oor;
    logic err_q;

    assign oor     = ({1'b0, gnt_addr} >= DEPTH_X);
    assign rsp_err = err_q;

    // Transaction FSM with out-of-range bypass straight to RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            last_gnt <= 1'b1;
            gnt_id   <= 1'b0;
            rom_addr <= '0;
            rsp_data <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    last_gnt <= gsel;
                    gnt_id   <= gsel;
                    if (oor) begin
                        state    <= S_RESP;
                        rsp_data <= '0;
                        err_q    <= 1'b1;
                    end else begin
                        state    <= S_ISSUE;
                        rom_addr <= gnt_addr;
                        err_q    <= 1'b0;
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    rsp_data <= rom_data;
                    state    <= S_RESP;
                end
                S_RESP:  if (rsp_hs) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
`else
    // Only the low clog2(DEPTH) address bits reach the ROM
    localparam int AW = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'((64'd1 << AW) - 64'd1);

    assign rsp_err = 1'b0;

    // Transaction FSM; every accepted request goes through the ROM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            last_gnt <= 1'b1;
            gnt_id   <= 1'b0;
            rom_addr <= '0;
            rsp_data <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    last_gnt <= gsel;
                    gnt_id   <= gsel;
                    rom_addr <= gnt_addr & ADDR_MASK;
                    state    <= S_ISSUE;
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    rsp_data <= rom_data;
                    state    <= S_RESP;
                end
                S_RESP:  if (rsp_hs) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed vector table, reset-in-flight sequence and a
// randomized run against a transaction-level model of the arbiter.
module tb_rom_arbiter;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req0_valid, req1_valid;
    logic [ADDR_W-1:0] req0_addr, req1_addr;
    logic              req0_ready, req1_ready;
    logic              rsp0_valid, rsp1_valid;
    logic              rsp0_ready, rsp1_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    int checks = 0;
    int errors = 0;
    int last_g = 1;

    rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data)
    );

    always #5 clk = ~clk;

    // ROM: word at address a is (a+3) mod 16, returned one cycle after rom_en;
    // garbage otherwise so a mistimed capture shows up
    always @(posedge clk)
        rom_data <= rom_en ? DATA_W'(rom_addr + 8'd3) : DATA_W'($urandom);

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: who is granted and what the requester should see
    task automatic model(input bit v0, input int a0, input bit v1, input int a1,
                         output int eg, output int elat, output int edata,
                         output int eerr, output int een, output int eaddr);
        int ea;
        eg = (v0 && v1) ? (last_g == 0 ? 1 : 0) : (v1 ? 1 : 0);
        ea = eg ? a1 : a0;
`ifdef ROM_ARB_RANGE_CHECK_EN
        if (ea >= DEPTH) begin
            elat = 1; edata = 0; eerr = 1; een = 0; eaddr = -1;
            return;
        end
        eaddr = ea;
`else
        eaddr = ea % (1 << $clog2(DEPTH));
`endif
        elat = 3; edata = (eaddr + 3) % 16; eerr = 0; een = 1;
    endtask

    // One full transaction; hold = cycles rspN_ready is kept low in RESP
    task automatic txn(input bit v0, input int a0, input bit v1, input int a1,
                       input int hold, output int g, output int lat, output int data,
                       output int err, output int en_cnt, output int en_addr);
        int n, leak;
        bit got;
        g = -1; lat = -1; data = -1; err = -1; en_cnt = 0; en_addr = -1; leak = 0;
        @(negedge clk);
        req0_valid = v0; req0_addr = ADDR_W'(a0);
        req1_valid = v1; req1_addr = ADDR_W'(a1);
        #1;
        n = 0;
        while (!(req0_ready || req1_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (!(req0_ready || req1_ready)) begin
            check("grant_timeout", 0, 1);
            req0_valid = 0; req1_valid = 0;
            return;
        end
        check("one_ready", int'(req0_ready) + int'(req1_ready), 1);
        g = req1_ready ? 1 : 0;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        got = 0;
        for (int k = 1; k <= 20 && !got; k++) begin
            if (k > 1) @(negedge clk);
            if (rom_en) begin en_cnt++; en_addr = int'(rom_addr); end
            if (req0_ready || req1_ready) leak++;
            if (rsp0_valid || rsp1_valid) begin got = 1; lat = k; end
        end
        check("ready_outside_idle", leak, 0);
        if (!got) begin
            check("rsp_timeout", 0, 1);
            return;
        end
        check("rsp_route", rsp1_valid ? 1 : 0, g);
        check("rsp_both", int'(rsp0_valid & rsp1_valid), 0);
        data = int'(rsp_data); err = int'(rsp_err);
        if (hold > 0) begin
            // competing request and the other requester's ready must both be ignored
            req0_valid = 1; req0_addr = ADDR_W'(a0);
            if (g == 0) rsp1_ready = 1; else rsp0_ready = 1;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk); #1;
            check("hold_valid", g ? int'(rsp1_valid) : int'(rsp0_valid), 1);
            check("hold_data", int'(rsp_data), data);
            check("hold_no_grant", int'(req0_ready | req1_ready), 0);
        end
        rsp0_ready = 0; rsp1_ready = 0;
        if (g == 0) rsp0_ready = 1; else rsp1_ready = 1;
        @(negedge clk);
        rsp0_ready = 0; rsp1_ready = 0; req0_valid = 0; req1_valid = 0;
        check("rsp_dropped", int'(rsp0_valid | rsp1_valid), 0);
    endtask

    typedef struct {
        bit v0; int a0; bit v1; int a1; int hold;
        int eg; int elat; int edata; int eerr; int een; int eaddr;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int g, lat, data, err, en, ea;
        int eg, elat, edata, eerr, een, eaddr, seen;
        bit v0, v1;
        int a0, a1, hold;

        vecs[0] = '{1, 1, 1, 2, 0, 0, 3, 4, 0, 1, 1};
        vecs[1] = '{1, 1, 1, 2, 0, 1, 3, 5, 0, 1, 2};
        vecs[2] = '{1, 1, 1, 2, 1, 0, 3, 4, 0, 1, 1};
        vecs[3] = '{1, 1, 1, 2, 0, 1, 3, 5, 0, 1, 2};
        vecs[4] = '{1, 3, 0, 0, 0, 0, 3, 6, 0, 1, 3};
        vecs[5] = '{0, 0, 1, 5, 5, 1, 3, 8, 0, 1, 5};
`ifdef ROM_ARB_RANGE_CHECK_EN
        vecs[6] = '{1, 8, 0, 0, 2, 0, 1, 0, 1, 0, -1};
        vecs[8] = '{1, 13, 1, 6, 0, 0, 1, 0, 1, 0, -1};
`else
        vecs[6] = '{1, 8, 0, 0, 2, 0, 3, 3, 0, 1, 0};
        vecs[8] = '{1, 13, 1, 6, 0, 0, 3, 8, 0, 1, 5};
`endif
        vecs[7] = '{0, 0, 1, 7, 0, 1, 3, 10, 0, 1, 7};

        rst_n = 0;
        req0_valid = 1; req1_valid = 1; req0_addr = 0; req1_addr = 0;
        rsp0_ready = 0; rsp1_ready = 0;
        #12;
        check("rst_ready", int'(req0_ready | req1_ready), 0);
        check("rst_rsp_valid", int'(rsp0_valid | rsp1_valid), 0);
        check("rst_rom_en", int'(rom_en), 0);
        check("rst_rom_addr", int'(rom_addr), 0);
        check("rst_rsp_data", int'(rsp_data), 0);
        check("rst_rsp_err", int'(rsp_err), 0);
        req0_valid = 0; req1_valid = 0;
        @(negedge clk); rst_n = 1;

        // Directed table
        foreach (vecs[i]) begin
            txn(vecs[i].v0, vecs[i].a0, vecs[i].v1, vecs[i].a1, vecs[i].hold,
                g, lat, data, err, en, ea);
            check($sformatf("vec%0d_grant", i), g, vecs[i].eg);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].elat);
            check($sformatf("vec%0d_data", i), data, vecs[i].edata);
            check($sformatf("vec%0d_err", i), err, vecs[i].eerr);
            check($sformatf("vec%0d_rom_en_cycles", i), en, vecs[i].een);
            check($sformatf("vec%0d_rom_addr", i), ea, vecs[i].eaddr);
            last_g = vecs[i].eg;
        end

        // Reset while the ROM read is in flight
        @(negedge clk);
        req0_valid = 1; req0_addr = 2; #1;
        check("rstseq_grant", int'(req0_ready), 1);
        @(negedge clk);
        req0_valid = 0;
        check("rstseq_issue", int'(rom_en), 1);
        @(negedge clk);
        req0_valid = 1; req1_valid = 1;
        rst_n = 0; #1;
        check("rstseq_rom_en", int'(rom_en), 0);
        check("rstseq_rom_addr", int'(rom_addr), 0);
        check("rstseq_rsp_data", int'(rsp_data), 0);
        check("rstseq_rsp_err", int'(rsp_err), 0);
        check("rstseq_rsp_valid", int'(rsp0_valid | rsp1_valid), 0);
        check("rstseq_ready", int'(req0_ready | req1_ready), 0);
        @(negedge clk);
        req0_valid = 0; req1_valid = 0; rst_n = 1;
        last_g = 1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid || rom_en) seen++;
        end
        check("rstseq_no_rsp", seen, 0);
        txn(1, 4, 1, 5, 0, g, lat, data, err, en, ea);
        check("rstseq_tie_grant", g, 0);
        check("rstseq_data", data, 7);
        check("rstseq_latency", lat, 3);
        last_g = 0;

        // Randomized traffic against the model
        for (int it = 0; it < 40; it++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            a0 = int'($urandom_range(0, 15));
            a1 = int'($urandom_range(0, 15));
            hold = int'($urandom_range(0, 3));
            model(v0, a0, v1, a1, eg, elat, edata, eerr, een, eaddr);
            txn(v0, a0, v1, a1, hold, g, lat, data, err, en, ea);
            check($sformatf("rnd%0d_grant", it), g, eg);
            check($sformatf("rnd%0d_latency", it), lat, elat);
            check($sformatf("rnd%0d_data", it), data, edata);
            check($sformatf("rnd%0d_err", it), err, eerr);
            check($sformatf("rnd%0d_rom_en", it), en, een);
            check($sformatf("rnd%0d_rom_addr", it), ea, eaddr);
            last_g = eg;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, requester address width.
REQ-002 SHALL have parameter DATA_W, default 4, ROM word width.
REQ-003 SHALL have parameter DEPTH, default 8, number of valid ROM words.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports req0_valid / req1_valid  input  1  read request from requester 0 / 1.
REQ-007 SHALL have ports req0_addr / req1_addr  input  ADDR_W  requested word address.
REQ-008 SHALL have ports req0_ready / req1_ready  output  1  request accepted this cycle.
REQ-009 SHALL have ports rsp0_valid / rsp1_valid  output  1  response available to requester 0 / 1.
REQ-010 SHALL have ports rsp0_ready / rsp1_ready  input  1  requester consumes response.
REQ-011 SHALL have port rsp_data  output  DATA_W  response word, shared by both requesters.
REQ-012 SHALL have port rsp_err  output  1  response is an out-of-range error.
REQ-013 SHALL have port rom_en  output  1  ROM read strobe.
REQ-014 SHALL have port rom_addr  output  ADDR_W  ROM read address.
REQ-015 SHALL have port rom_data  input  DATA_W  ROM read data, valid one cycle after rom_en.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; single outstanding transaction.
REQ-017 IDLE: SHALL assert reqN_ready combinationally for exactly one requester (the granted one) when any reqN_valid is high; acceptance = valid & ready on a rising edge; next state ISSUE.
REQ-018 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it; last-grant pointer resets to 1 (requester 0 wins first tie).
REQ-019 On acceptance SHALL latch granted address and requester ID; requesters keep valid/addr stable until ready.
REQ-020 ISSUE: rom_en=1, rom_addr=latched address, for exactly one cycle; next state WAIT.
REQ-021 WAIT: SHALL capture rom_data into rsp_data at end of cycle; next state RESP.
REQ-022 RESP: SHALL hold rspN_valid high for the latched requester only, rsp_data stable, until rspN_ready; on handshake edge return to IDLE.
REQ-023 Latency SHALL be: rspN_valid high in the 3rd cycle after the acceptance edge.
REQ-024 rom_en SHALL be 0 and rom_addr SHALL hold its last value outside ISSUE; reqN_ready SHALL be 0 outside IDLE.
REQ-025 New request SHALL be accepted no earlier than the cycle after the response handshake (no overlap).
REQ-026 rspN_ready asserted while rspN_valid low SHALL be ignored.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, reqN_ready=0, rspN_valid=0, rom_en=0, rom_addr=0, rsp_data=0, rsp_err=0, last-grant=1.
REQ-028 Reset mid-transaction SHALL drop it silently; no response after release.

Configuration
REQ-029 Macro ROM_ARB_RANGE_CHECK_EN defined: accepted address >= DEPTH SHALL skip ISSUE/WAIT, go directly to RESP with rsp_data=0, rsp_err=1, rom_en never asserted; in-range responses have rsp_err=0.
REQ-030 Macro undefined: no range check; rom_addr = latched address with upper bits zeroed above clog2(DEPTH); rsp_err tied 0.

Verification
REQ-031 Req0 addr 3 alone, rom_data returns 4'h6 -> rom_en one cycle with rom_addr 3, rsp0_valid 3 cycles after acceptance, rsp_data 4'h6.
REQ-032 Req0 and req1 valid together for 4 transactions -> grants 0,1,0,1; each response routed to correct rspN_valid.
REQ-033 Hold rsp1_ready low 5 cycles in RESP -> rsp1_valid and rsp_data stable 5 cycles, no new grant until handshake.
REQ-034 With ROM_ARB_RANGE_CHECK_EN, req0 addr 8 -> no rom_en, rsp0_valid 1 cycle after acceptance state entry, rsp_err=1, rsp_data=0; without macro, addr 8 -> rom_addr 0.
REQ-035 Pulse rst_n low during WAIT -> outputs at reset values immediately, no response after release, next request served normally with requester 0 winning a tie.
